// File: rtl/mgia_sync_monitor.sv
// MGIA video timing receiver: recovers dot/line position, display enable and lock from HSYNC/VSYNC.
// Optional build macro MGIA_SYNC_WIDTH_CHECK_EN adds HSYNC/VSYNC low-width checks.
module mgia_sync_monitor #(
  parameter int unsigned H_TOTAL     = 795,
  parameter int unsigned H_SYNC_W    = 94,
  parameter int unsigned H_ACT_OFS   = 131,
  parameter int unsigned H_ACT_LEN   = 640,
  parameter int unsigned V_TOTAL     = 526,
  parameter int unsigned V_SYNC_W    = 2,
  parameter int unsigned V_ACT_OFS   = 72,
  parameter int unsigned V_ACT_LEN   = 400,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       HSYNC_I,
  input  logic       VSYNC_I,
  output logic [9:0] DOT_O,
  output logic [9:0] LINE_O,
  output logic       DE_O,
  output logic       FRAME_O,
  output logic       LOCKED_O,
  output logic       ERR_O,
  output logic [7:0] ERRCNT_O
);

  localparam logic [9:0] CntMax    = 10'h3ff;
  localparam logic [9:0] HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActFirst = 10'(H_ACT_OFS);
  localparam logic [9:0] HActLast  = 10'(H_ACT_OFS + H_ACT_LEN - 1);
  localparam logic [9:0] VActFirst = 10'(V_ACT_OFS);
  localparam logic [9:0] VActLast  = 10'(V_ACT_OFS + V_ACT_LEN - 1);

  localparam int unsigned CleanW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [CleanW-1:0] LockLast = CleanW'(LOCK_FRAMES - 1);

  localparam logic [1:0] StSearch = 2'd0;
  localparam logic [1:0] StVerify = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  logic              hs_s_q, hs_p_q, vs_s_q, vs_p_q;
  logic              h_fall, v_fall;
  logic [9:0]        dot_q, dot_d, line_q, line_d;
  logic              dot_sat_q, line_sat_q;
  logic              dot_to, line_to;
  logic [1:0]        state_q, state_d;
  logic [CleanW-1:0] clean_q, clean_d;
  logic              h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic              period_bad, width_bad, viol, err_d;
  logic              de_q, de_d, frame_q, err_q;
  logic [7:0]        errcnt_q, errcnt_d;

  // Edges are taken between the sync register and its delayed copy.
  assign h_fall = hs_p_q & ~hs_s_q;
  assign v_fall = vs_p_q & ~vs_s_q;

  always_comb begin
    dot_d = dot_q;
    if (h_fall) begin
      dot_d = '0;
    end else if (dot_q != CntMax) begin
      dot_d = dot_q + 10'd1;
    end
  end

  always_comb begin
    line_d = line_q;
    if (v_fall) begin
      line_d = '0;
    end else if (h_fall && (line_q != CntMax)) begin
      line_d = line_q + 10'd1;
    end
  end

  // Timeouts fire once, in the first cycle a counter sits at its ceiling.
  assign dot_to  = (dot_q == CntMax) & ~dot_sat_q;
  assign line_to = (line_q == CntMax) & ~line_sat_q;

  assign period_bad = (h_fall & h_seen_q & (dot_q != HLast)) |
                      (v_fall & v_seen_q & (line_q != VLast));

`ifdef MGIA_SYNC_WIDTH_CHECK_EN
  localparam logic [9:0]  HSyncW = 10'(H_SYNC_W);
  localparam logic [10:0] VSyncW = 11'(V_SYNC_W);

  logic        h_rise, v_rise;
  logic [9:0]  hw_q, hw_d;
  logic [10:0] vs_lines;

  assign h_rise = ~hs_p_q & hs_s_q;
  assign v_rise = ~vs_p_q & vs_s_q;

  // Counts registered low samples of HSYNC; equals the pulse width on the rise.
  always_comb begin
    hw_d = hw_q;
    if (h_fall) begin
      hw_d = 10'd1;
    end else if (!hs_s_q && (hw_q != CntMax)) begin
      hw_d = hw_q + 10'd1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      hw_q <= '0;
    end else begin
      hw_q <= hw_d;
    end
  end

  // The line counter already holds HSYNC falls since the VSYNC fall.
  assign vs_lines  = {1'b0, line_q} + {10'd0, h_fall};
  assign width_bad = (h_rise & h_seen_q & (hw_q != HSyncW)) |
                     (v_rise & v_seen_q & (vs_lines != VSyncW));
`else
  logic unused_width_cfg;
  assign unused_width_cfg = ^{10'(H_SYNC_W), 10'(V_SYNC_W)};
  assign width_bad        = 1'b0;
`endif

  assign viol  = period_bad | width_bad | dot_to | line_to;
  assign err_d = viol & (state_q != StSearch);

  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    unique case (state_q)
      StSearch: begin
        if (v_fall) begin
          state_d = StVerify;
          clean_d = '0;
        end
      end
      StVerify: begin
        if (viol) begin
          state_d = StSearch;
        end else if (v_fall) begin
          if (clean_q == LockLast) begin
            state_d = StLocked;
          end else begin
            clean_d = clean_q + 1'b1;
          end
        end
      end
      StLocked: begin
        if (viol) begin
          state_d = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // A period is only measured once its opening edge was seen outside SEARCH.
  always_comb begin
    h_seen_d = h_seen_q;
    v_seen_d = v_seen_q;
    if (state_d == StSearch) begin
      h_seen_d = 1'b0;
      v_seen_d = 1'b0;
    end else begin
      if (h_fall) h_seen_d = 1'b1;
      if (v_fall) v_seen_d = 1'b1;
    end
  end

  always_comb begin
    de_d = (dot_q >= HActFirst) && (dot_q <= HActLast) &&
           (line_q >= VActFirst) && (line_q <= VActLast) && (state_d == StLocked);
  end

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d && (errcnt_q != 8'hff)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      hs_s_q     <= 1'b1;
      hs_p_q     <= 1'b1;
      vs_s_q     <= 1'b1;
      vs_p_q     <= 1'b1;
      dot_q      <= '0;
      line_q     <= '0;
      dot_sat_q  <= 1'b0;
      line_sat_q <= 1'b0;
      state_q    <= StSearch;
      clean_q    <= '0;
      h_seen_q   <= 1'b0;
      v_seen_q   <= 1'b0;
      de_q       <= 1'b0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
      errcnt_q   <= '0;
    end else begin
      hs_s_q     <= HSYNC_I;
      hs_p_q     <= hs_s_q;
      vs_s_q     <= VSYNC_I;
      vs_p_q     <= vs_s_q;
      dot_q      <= dot_d;
      line_q     <= line_d;
      dot_sat_q  <= (dot_q == CntMax);
      line_sat_q <= (line_q == CntMax);
      state_q    <= state_d;
      clean_q    <= clean_d;
      h_seen_q   <= h_seen_d;
      v_seen_q   <= v_seen_d;
      de_q       <= de_d;
      frame_q    <= v_fall;
      err_q      <= err_d;
      errcnt_q   <= errcnt_d;
    end
  end

  assign DOT_O    = dot_q;
  assign LINE_O   = line_q;
  assign DE_O     = de_q;
  assign FRAME_O  = frame_q;
  assign LOCKED_O = (state_q == StLocked);
  assign ERR_O    = err_q;
  assign ERRCNT_O = errcnt_q;

endmodule
